// File: rtl/internal_pkg.sv
// Shared types and register-window constants for the internal packet bus sync blocks.
// Offsets are relative to each channel's 4-word slot; CTRL bit indices select fields of the CTRL data word.
package internal_pkg;

    localparam int SB_ADDR_W = 16;

    localparam int SB_STRIDE = 4;
    localparam logic [1:0] SB_OFF_LOAD   = 2'd0;
    localparam logic [1:0] SB_OFF_RELOAD = 2'd1;
    localparam logic [1:0] SB_OFF_DEC    = 2'd2;
    localparam logic [1:0] SB_OFF_CTRL   = 2'd3;

    localparam int SB_CTRL_AUTO   = 0;
    localparam int SB_CTRL_STICKY = 1;
    localparam int SB_CTRL_CLR    = 2;

    typedef struct packed {
        logic                 valid;
        logic [SB_ADDR_W-1:0] addr;
        logic [63:0]          data;
    } t_if_internal;

    typedef struct packed {
        logic auto_reload;
        logic sticky;
    } t_sb_ctrl;

endpackage

// File: rtl/sync_channel.sv
// One countdown channel: counter, reload value, control bits, sticky flag and registered zero event.
// hit_q is registered on the strobe edge; done is valid for the output registers on the following edge.
module sync_channel
    import internal_pkg::*;
#(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ld,
    input  logic             rl,
    input  logic             dec,
    input  logic             cw,
    input  logic [CNT_W-1:0] data,
    input  logic [2:0]       ctrl_bits,
    output logic             done,
    output logic             hit_q
);

    t_sb_ctrl         ctrl;
    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] reload;
    logic [CNT_W-1:0] counter_nxt;
    logic             hit;
    logic             flag;
    logic             flag_nxt;
    logic             clr_q;

    always_comb begin
        counter_nxt = counter;
        hit         = 1'b0;
        if (ld) begin
            counter_nxt = data;
            hit         = (data == '0) && (counter != '0);
        end else if (dec && (counter != '0)) begin
            if ((counter == CNT_W'(1)) && ctrl.auto_reload) begin
                counter_nxt = reload;
                hit         = 1'b1;
            end else begin
                counter_nxt = counter - CNT_W'(1);
                hit         = (counter == CNT_W'(1));
            end
        end
    end

    // Set beats a coincident clear so no zero event is dropped.
    assign flag_nxt = hit_q | (flag & ~clr_q);
    // Uses the flag value being written this edge so sticky and level modes share the same latency.
    assign done     = ctrl.sticky ? flag_nxt : (counter == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            counter <= '1;
            reload  <= '1;
            ctrl    <= '0;
            flag    <= 1'b0;
            clr_q   <= 1'b0;
            hit_q   <= 1'b0;
        end else begin
            counter <= counter_nxt;
            hit_q   <= hit;
            flag    <= flag_nxt;
            clr_q   <= cw & ctrl_bits[SB_CTRL_CLR];
            if (rl) reload <= data;
            if (cw) begin
                ctrl.auto_reload <= ctrl_bits[SB_CTRL_AUTO];
                ctrl.sticky      <= ctrl_bits[SB_CTRL_STICKY];
            end
        end
    end

endmodule

// File: rtl/sync_barrier.sv
// NUM_CH countdown channels on the internal bus with per-channel sync, event pulse and masked barrier.
// Outputs reflect a packet two edges after it is sampled; no backpressure, one packet per cycle.
module sync_barrier
    import internal_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int CNT_W     = 64,
    parameter int BASE_ADDR = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  t_if_internal      pkt_in,
    output logic [NUM_CH-1:0] sync,
    output logic [NUM_CH-1:0] sync_pulse,
    output logic              barrier
);

    logic [NUM_CH-1:0]    ld, rl, dec, cw;
    logic                 mask_wr;
    logic                 in_win;
    logic [SB_ADDR_W-1:0] off;
    logic [NUM_CH-1:0]    mask;
    logic [NUM_CH-1:0]    done;
    logic [NUM_CH-1:0]    hit_q;

    always_comb begin
        ld      = '0;
        rl      = '0;
        dec     = '0;
        cw      = '0;
        off     = pkt_in.addr - SB_ADDR_W'(BASE_ADDR);
        in_win  = pkt_in.valid && (pkt_in.addr >= SB_ADDR_W'(BASE_ADDR));
        mask_wr = in_win && (off == SB_ADDR_W'(SB_STRIDE * NUM_CH));
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (in_win && (off[SB_ADDR_W-1:2] == (SB_ADDR_W-2)'(ch))) begin
                ld[ch]  = (off[1:0] == SB_OFF_LOAD);
                rl[ch]  = (off[1:0] == SB_OFF_RELOAD);
                dec[ch] = (off[1:0] == SB_OFF_DEC);
                cw[ch]  = (off[1:0] == SB_OFF_CTRL);
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        sync_channel #(.CNT_W(CNT_W)) u_ch (
            .clk       (clk),
            .reset     (reset),
            .ld        (ld[g]),
            .rl        (rl[g]),
            .dec       (dec[g]),
            .cw        (cw[g]),
            .data      (pkt_in.data[CNT_W-1:0]),
            .ctrl_bits (pkt_in.data[2:0]),
            .done      (done[g]),
            .hit_q     (hit_q[g])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask       <= '0;
            sync       <= '0;
            sync_pulse <= '0;
            barrier    <= 1'b0;
        end else begin
            if (mask_wr) mask <= pkt_in.data[NUM_CH-1:0];
            sync       <= done;
            sync_pulse <= hit_q;
            barrier    <= (mask != '0) && (&(done | ~mask));
        end
    end

endmodule

// File: doc/sync_barrier.md
# sync_barrier

Multi-channel successor to the single-counter sync block on the internal packet bus. It provides NUM_CH independent countdown channels. Each channel can be loaded, decremented, auto-reloaded and configured for level or sticky completion. A masked barrier output asserts when every selected channel has completed. The block sits beside the other internal-bus consumers and drives host-visible sync status.

## Interface
- NUM_CH, 4: number of countdown channels, 1..8.
- CNT_W, 64: counter width, 1..64; loads use pkt_in.data[CNT_W-1:0].
- BASE_ADDR, 128: first word address of the block's register window.
- clk  input  1  single clock; all state on posedge.
- reset  input  1  asynchronous, active-low; clears all state immediately, no clock required.
- pkt_in  input  t_if_internal  internal bus packet (valid, addr, data[63:0]); one packet per cycle, no backpressure.
- sync  output  NUM_CH  per-channel completion, registered.
- sync_pulse  output  NUM_CH  one-cycle pulse per zero event, registered.
- barrier  output  1  all masked channels complete, registered.

## Operation
- Address map per channel ch has stride 4, at A = BASE_ADDR + 4*ch.
  - A+0 LOAD: counter <= data.
  - A+1 RELOAD: reload <= data.
  - A+2 DEC: counter decremented by 1; data ignored.
  - A+3 CTRL: data[0] auto_reload, data[1] sticky, data[2] clear_flag (self-clearing command, not stored).
- BASE_ADDR + 4*NUM_CH is MASK: mask <= data[NUM_CH-1:0].
- A packet is acted on only when pkt_in.valid=1. Addresses outside the window are ignored.
- DEC behaviour:
  - At counter 0 the counter saturates: it stays 0 and no event is raised.
  - At counter 1 with auto_reload=1, counter <= reload.
  - In all other cases, counter <= counter-1.
- hit[ch] (zero event) is raised when either condition holds:
  - the counter transitions from nonzero to 0, by LOAD or DEC;
  - an auto-reload occurs.
  - LOAD 0 onto a counter already at 0 raises no hit.
  - Auto-reload with reload=0 yields counter 0 with exactly one hit.
- Flag behaviour:
  - flag[ch] is set by hit and cleared by CTRL clear_flag.
  - Set wins over a simultaneous clear, so no event is lost.
- Completion definition: done[ch] = sticky ? flag : (counter==0).
- sync = done.
- sync_pulse = hit, delayed per Timing.
- barrier = (mask != 0) && ((done | ~mask) all ones). barrier=0 when mask=0.
- Reset values:
  - counter all ones; reload all ones.
  - auto_reload=0, sticky=0, flag=0, mask=0.
  - sync=0, sync_pulse=0, barrier=0.

## Timing
- Packet sampled at edge k:
  - counter, reload, ctrl and mask update at edge k.
  - hit is registered at edge k (hit_q).
- Edge k+1:
  - flag updates from hit_q.
  - sync, sync_pulse (<= hit_q) and barrier update.
  - Outputs therefore reflect a packet two edges after sampling.
- sync_pulse is high for exactly one cycle per hit.
- Back-to-back DECs produce back-to-back pulses.
- The CTRL sticky bit takes effect on done at edge k+1. A sticky 1->0 switch exposes the level value immediately.
- Asynchronous reset assertion mid-count zeroes all outputs without a clock edge. Deassertion is synchronised by the integrator; the first packet is accepted on the first edge after release.

## Structure
- Constants belong in internal_pkg: SB_OFF_LOAD=0, SB_OFF_RELOAD=1, SB_OFF_DEC=2, SB_OFF_CTRL=3, SB_STRIDE=4, and CTRL bit indices.
- A t_sb_ctrl packed struct (auto_reload, sticky) also belongs in internal_pkg.
- Sub-module sync_channel holds one channel:
  - counter, reload, ctrl, flag, hit_q;
  - inputs: decoded ld/rl/dec/ctrl strobes plus data;
  - outputs: done and hit_q.
- The top level holds:
  - the address decode;
  - the mask register;
  - a generate loop of NUM_CH sync_channel instances;
  - the output registers.

## Test plan
1. Reset, then 16 DECs to addr 130: sync=0 throughout. Counter reads all ones minus 16; no pulse.
2. LOAD addr 128 data 3, then 3 DECs at addr 130:
   - sync[0] rises two edges after the third DEC;
   - sync_pulse[0] is high for one cycle;
   - a 4th DEC keeps sync[0]=1 with no pulse.
3. Channel 1 auto-reload and sticky:
   - RELOAD addr 133 data 2, CTRL addr 135 data 0b011, LOAD addr 132 data 2, then 2 DECs at addr 134;
   - expect one pulse, counter=2 and sync[1] held high;
   - CTRL data 0b111 drops sync[1] two edges later while auto_reload stays set.
4. Barrier:
   - MASK addr 144 data 0b0101; LOAD ch0 (128) and ch2 (136) data 1;
   - DEC ch0 at 130: barrier stays 0;
   - DEC ch2 at 138: barrier rises on the same edge as sync[2].
5. Load ch0 with 5, DEC twice, then assert reset between clock edges: sync, sync_pulse and barrier go 0 immediately. After release, counter=all ones.
6. Ignored packets:
   - valid=1 at addr 127 and addr 145;
   - valid=0 at addr 130;
   - expect no state change and no pulse.
